// File: rtl/gecko_axi_program_loader_if.sv
// AXI4 write-channel bundle (AW/W/B) between the program loader and a memory slave.
// The master modport is the loader side, the slave modport the memory side.
interface gecko_axi_program_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
);
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [7:0]            axi_awlen;
    logic [2:0]            axi_awsize;
    logic [1:0]            axi_awburst;
    logic [ID_WIDTH-1:0]   axi_awid;
    logic [3:0]            axi_awcache;
    logic [2:0]            axi_awprot;
    logic [3:0]            axi_awqos;
    logic                  axi_awlock;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [DATA_WIDTH-1:0] axi_wdata;
    logic [3:0]            axi_wstrb;
    logic                  axi_wlast;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [1:0]            axi_bresp;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
               axi_awcache, axi_awprot, axi_awqos, axi_awlock,
               axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
               axi_awcache, axi_awprot, axi_awqos, axi_awlock,
               axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp
    );
endinterface

// File: rtl/gecko_axi_program_loader.sv
// Streams program words into memory as AXI4 INCR write bursts, one burst outstanding, no 4 KB crossing.
// Optional macro GECKO_LOADER_BRESP_CHECK_EN: a non-OKAY bresp sets the sticky error flag and aborts the command.
module gecko_axi_program_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [15:0]                cmd_words,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    gecko_axi_program_loader_if.master axi,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FINISH} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [15:0]           remaining_reg;
    logic [7:0]            len_reg;
    logic [7:0]            beat_reg;
    logic                  error_reg;

    logic [10:0]           room_words;
    logic [16:0]           burst_beats;
    logic [8:0]            beats_done;
    logic                  last_beat;
    logic                  resp_err;

`ifdef GECKO_LOADER_BRESP_CHECK_EN
    assign resp_err = (axi.axi_bresp != 2'b00);
`else
    logic bresp_unused;
    assign bresp_unused = ^axi.axi_bresp;
    assign resp_err     = 1'b0;
`endif

    // Words left before the next 4 KB boundary: 1..1024, since addr_reg is word aligned.
    assign room_words = 11'h400 - {1'b0, addr_reg[11:2]};

    always_comb begin
        burst_beats = {1'b0, remaining_reg};
        if (17'(room_words) < burst_beats)
            burst_beats = 17'(room_words);
        if (17'(MAX_BURST) < burst_beats)
            burst_beats = 17'(MAX_BURST);
    end

    assign beats_done = {1'b0, len_reg} + 9'd1;
    assign last_beat  = (beat_reg == len_reg);

    assign axi.axi_awaddr  = addr_reg;
    assign axi.axi_awlen   = 8'(burst_beats - 17'd1);
    assign axi.axi_awsize  = 3'b010;
    assign axi.axi_awburst = 2'b01;
    assign axi.axi_awid    = '0;
    assign axi.axi_awcache = 4'd0;
    assign axi.axi_awprot  = 3'd0;
    assign axi.axi_awqos   = 4'd0;
    assign axi.axi_awlock  = 1'b0;
    assign axi.axi_wdata   = in_data;
    assign axi.axi_wstrb   = 4'hF;
    assign axi.axi_wlast   = (state_reg == DATA) && last_beat;
    assign error           = error_reg && rst;

    always_comb begin
        state_next      = state_reg;
        cmd_ready       = 1'b0;
        in_ready        = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
        axi.axi_bready  = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = (cmd_words == 16'd0) ? FINISH : ADDR;
            end
            ADDR: begin
                axi.axi_awvalid = 1'b1;
                if (axi.axi_awready)
                    state_next = DATA;
            end
            DATA: begin
                axi.axi_wvalid = in_valid;
                in_ready       = axi.axi_wready;
                if (in_valid && axi.axi_wready && last_beat)
                    state_next = RESP;
            end
            RESP: begin
                axi.axi_bready = 1'b1;
                if (axi.axi_bvalid) begin
                    if (resp_err || remaining_reg == 16'(beats_done))
                        state_next = FINISH;
                    else
                        state_next = ADDR;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_reg != IDLE)
            busy = 1'b1;
        // Everything handshake-related is held low for the whole time reset is asserted.
        if (!rst) begin
            cmd_ready       = 1'b0;
            in_ready        = 1'b0;
            busy            = 1'b0;
            done            = 1'b0;
            axi.axi_awvalid = 1'b0;
            axi.axi_wvalid  = 1'b0;
            axi.axi_bready  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= 16'd0;
            len_reg       <= 8'd0;
            beat_reg      <= 8'd0;
            error_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_reg      <= cmd_addr & ~ADDR_WIDTH'(3);
                        remaining_reg <= cmd_words;
                    end
                end
                ADDR: begin
                    if (axi.axi_awready) begin
                        len_reg  <= axi.axi_awlen;
                        beat_reg <= 8'd0;
                    end
                end
                DATA: begin
                    if (axi.axi_wvalid && axi.axi_wready)
                        beat_reg <= beat_reg + 8'd1;
                end
                RESP: begin
                    if (axi.axi_bvalid) begin
                        if (resp_err) begin
                            error_reg     <= 1'b1;
                            remaining_reg <= 16'd0;
                        end else begin
                            addr_reg      <= addr_reg + ADDR_WIDTH'({beats_done, 2'b00});
                            remaining_reg <= remaining_reg - 16'(beats_done);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gecko_axi_program_loader.sv
// Directed bench for gecko_axi_program_loader: an AXI memory slave model with optional random stalls,
// a word source, and hand-computed burst/address expectations per command.
module tb_gecko_axi_program_loader;
    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_words;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        busy;
    logic        done;
    logic        error;

    gecko_axi_program_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) axi_bus ();

    gecko_axi_program_loader #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .axi(axi_bus),
        .busy(busy), .done(done), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave / source model state
    int          cyc = 0;
    bit          stall = 1'b0;
    int          err_burst = -1;
    logic [31:0] src [128];
    int          src_n = 0;
    int          src_idx = 0;
    logic [31:0] aw_addr_q [$];
    logic [7:0]  aw_len_q [$];
    logic [31:0] mem_data [logic [31:0]];
    int          mem_cnt [logic [31:0]];
    int          total_beats = 0;
    int          burst_no = 0;
    bit          aw_out = 1'b0;
    bit          b_pending = 1'b0;
    bit          b_ack = 1'b0;
    bit          prev_done = 1'b0;
    logic [31:0] cur_addr = 32'd0;
    logic [7:0]  cur_len = 8'd0;
    int          beat = 0;
    logic [31:0] wa;
    int          wlast_err = 0;
    int          ot_viol = 0;
    int          ready_viol = 0;
    int          done_wid_viol = 0;
    int          const_viol = 0;
    int          done_cnt = 0;
    int          last_b_cyc = 0;
    int          last_done_cyc = 0;
    int          last_cmd_cyc = 0;

    // Drive slave/source inputs on the falling edge, then observe the handshakes that the next rising edge takes.
    initial begin
        axi_bus.axi_awready = 1'b0;
        axi_bus.axi_wready  = 1'b0;
        axi_bus.axi_bvalid  = 1'b0;
        axi_bus.axi_bresp   = 2'b00;
        in_valid = 1'b0;
        in_data  = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (b_ack) begin
                axi_bus.axi_bvalid = 1'b0;
                b_ack = 1'b0;
            end
            axi_bus.axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_bus.axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_pending && !axi_bus.axi_bvalid)
                axi_bus.axi_bvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_bus.axi_bresp = (burst_no == err_burst) ? 2'b10 : 2'b00;
            if (src_idx < src_n) begin
                in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = src[src_idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 32'd0;
            end
            #1;
            if (!rst) begin
                aw_out = 1'b0;
                b_pending = 1'b0;
                b_ack = 1'b0;
                axi_bus.axi_bvalid = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready)
                    last_cmd_cyc = cyc;
                if (cmd_ready && busy)
                    ready_viol++;
                if (in_ready && (axi_bus.axi_awvalid || axi_bus.axi_bready || !busy || done))
                    ready_viol++;
                if (axi_bus.axi_awvalid && axi_bus.axi_awready) begin
                    if (aw_out)
                        ot_viol++;
                    if (axi_bus.axi_awsize != 3'b010 || axi_bus.axi_awburst != 2'b01 ||
                        axi_bus.axi_awid != 1'b0 || axi_bus.axi_awcache != 4'd0 ||
                        axi_bus.axi_awprot != 3'd0 || axi_bus.axi_awqos != 4'd0 ||
                        axi_bus.axi_awlock != 1'b0)
                        const_viol++;
                    aw_addr_q.push_back(axi_bus.axi_awaddr);
                    aw_len_q.push_back(axi_bus.axi_awlen);
                    cur_addr = axi_bus.axi_awaddr;
                    cur_len  = axi_bus.axi_awlen;
                    beat     = 0;
                    aw_out   = 1'b1;
                end
                if (axi_bus.axi_wvalid && axi_bus.axi_wready) begin
                    if (!aw_out || b_pending)
                        ot_viol++;
                    if (axi_bus.axi_wlast !== (beat == int'(cur_len)))
                        wlast_err++;
                    if (axi_bus.axi_wstrb != 4'hF)
                        const_viol++;
                    wa = cur_addr + 32'(beat * 4);
                    if (mem_cnt.exists(wa))
                        mem_cnt[wa]++;
                    else
                        mem_cnt[wa] = 1;
                    mem_data[wa] = axi_bus.axi_wdata;
                    total_beats++;
                    beat++;
                    if (beat > int'(cur_len))
                        b_pending = 1'b1;
                end
                if (in_valid && in_ready)
                    src_idx++;
                if (axi_bus.axi_bvalid && axi_bus.axi_bready) begin
                    if (!b_pending)
                        ot_viol++;
                    b_pending = 1'b0;
                    aw_out = 1'b0;
                    b_ack = 1'b1;
                    burst_no++;
                    last_b_cyc = cyc;
                end
                if (done) begin
                    if (prev_done)
                        done_wid_viol++;
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                prev_done = done;
            end
        end
    end

    task automatic prepare(input logic [31:0] a, input int n, input bit stl);
        aw_addr_q.delete();
        aw_len_q.delete();
        mem_data.delete();
        mem_cnt.delete();
        total_beats = 0;
        burst_no = 0;
        for (int i = 0; i < n; i++)
            src[i] = {a[15:0] ^ 16'h5A5A, 16'(i * 3 + 1)};
        src_idx = 0;
        src_n = n;
        stall = stl;
    endtask

    task automatic run_cmd(input string tag, input logic [31:0] a, input int n, input bit stl);
        int  d0;
        int  k;
        bit  acc;
        prepare(a, n, stl);
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_words = 16'(n);
        k = 0;
        acc = 1'b0;
        while (!acc && k < 100) begin
            #2;
            acc = cmd_ready;
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        check({tag, "_cmd_accept"}, 32'(acc), 32'd1);
        k = 0;
        while (done_cnt == d0 && k < 5000) begin
            @(negedge clk);
            #2;
            k++;
        end
        repeat (2) @(negedge clk);
        #2;
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        $display("[TB] cmd %s addr=0x%08h words=%0d bursts=%0d beats=%0d error=%0d",
                 tag, a, n, aw_addr_q.size(), total_beats, error);
    endtask

    task automatic check_aw(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
        if (idx < aw_addr_q.size()) begin
            check({tag, "_awaddr"}, aw_addr_q[idx], a);
            check({tag, "_awlen"}, 32'(aw_len_q[idx]), 32'(l));
        end else begin
            check({tag, "_aw_present"}, 32'(aw_addr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_data(input string tag, input logic [31:0] base, input int n);
        int          bad;
        logic [31:0] a;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(i * 4);
            if (!mem_cnt.exists(a))
                bad++;
            else if (mem_cnt[a] != 1 || mem_data[a] !== src[i])
                bad++;
        end
        check({tag, "_data"}, 32'(bad), 32'd0);
        check({tag, "_beats"}, 32'(total_beats), 32'(n));
    endtask

    initial begin
        int k;
        bit seen;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = 32'd0;
        cmd_words = 16'd0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_awvalid", 32'(axi_bus.axi_awvalid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        run_cmd("single", 32'h0000_0100, 4, 1'b0);
        check("single_aw_count", 32'(aw_addr_q.size()), 32'd1);
        check_aw("single_aw0", 0, 32'h0000_0100, 8'd3);
        check_data("single", 32'h0000_0100, 4);
        check("single_done_after_b", 32'(last_done_cyc - last_b_cyc), 32'd1);

        run_cmd("multi", 32'h0000_0000, 40, 1'b0);
        check("multi_aw_count", 32'(aw_addr_q.size()), 32'd3);
        check_aw("multi_aw0", 0, 32'h0000_0000, 8'd15);
        check_aw("multi_aw1", 1, 32'h0000_0040, 8'd15);
        check_aw("multi_aw2", 2, 32'h0000_0080, 8'd7);
        check_data("multi", 32'h0000_0000, 40);

        run_cmd("cross4k", 32'h0000_0FF8, 4, 1'b0);
        check("cross4k_aw_count", 32'(aw_addr_q.size()), 32'd2);
        check_aw("cross4k_aw0", 0, 32'h0000_0FF8, 8'd1);
        check_aw("cross4k_aw1", 1, 32'h0000_1000, 8'd1);
        check_data("cross4k", 32'h0000_0FF8, 4);

        run_cmd("zero", 32'h0000_0500, 0, 1'b0);
        check("zero_aw_count", 32'(aw_addr_q.size()), 32'd0);
        check("zero_beats", 32'(total_beats), 32'd0);
        check("zero_done_latency",
              32'((last_done_cyc - last_cmd_cyc) >= 1 && (last_done_cyc - last_cmd_cyc) <= 2), 32'd1);

        run_cmd("wrap", 32'hFFFF_FFF8, 4, 1'b0);
        check("wrap_aw_count", 32'(aw_addr_q.size()), 32'd2);
        check_aw("wrap_aw0", 0, 32'hFFFF_FFF8, 8'd1);
        check_aw("wrap_aw1", 1, 32'h0000_0000, 8'd1);
        check_data("wrap", 32'hFFFF_FFF8, 4);

        run_cmd("stall", 32'h0000_0FF3, 100, 1'b1);
        check("stall_aw_count", 32'(aw_addr_q.size()), 32'd7);
        check_aw("stall_aw0", 0, 32'h0000_0FF0, 8'd3);
        check_aw("stall_aw1", 1, 32'h0000_1000, 8'd15);
        check_aw("stall_aw6", 6, 32'h0000_1140, 8'd15);
        check_data("stall", 32'h0000_0FF0, 100);

        err_burst = 0;
        run_cmd("bresp", 32'h0000_0000, 40, 1'b0);
        err_burst = -1;
`ifdef GECKO_LOADER_BRESP_CHECK_EN
        check("bresp_aw_count", 32'(aw_addr_q.size()), 32'd1);
        check("bresp_beats", 32'(total_beats), 32'd16);
        check("bresp_error", 32'(error), 32'd1);
        run_cmd("after_err", 32'h0000_0800, 4, 1'b0);
        check("after_err_aw_count", 32'(aw_addr_q.size()), 32'd1);
        check_data("after_err", 32'h0000_0800, 4);
        check("after_err_error", 32'(error), 32'd1);
`else
        check("bresp_aw_count", 32'(aw_addr_q.size()), 32'd3);
        check_data("bresp", 32'h0000_0000, 40);
        check("bresp_error", 32'(error), 32'd0);
`endif

        // Reset in the middle of a data burst
        prepare(32'h0000_0200, 8, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0200;
        cmd_words = 16'd8;
        #2;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 50) begin
            #2;
            seen = axi_bus.axi_wvalid;
            if (!seen)
                @(negedge clk);
            k++;
        end
        check("rstmid_reached_data", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        src_n = 0;
        @(posedge clk);
        #1;
        check("rstmid_outputs",
              32'({axi_bus.axi_awvalid, axi_bus.axi_wvalid, axi_bus.axi_bready, in_ready,
                   cmd_ready, busy, done, error}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rstmid_idle_busy", 32'(busy), 32'd0);
        check("rstmid_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        $display("[TB] cmd rstmid addr=0x00000200 words=8 abandoned by reset");

        run_cmd("post_rst", 32'h0000_0600, 2, 1'b0);
        check("post_rst_aw_count", 32'(aw_addr_q.size()), 32'd1);
        check_aw("post_rst_aw0", 0, 32'h0000_0600, 8'd1);
        check_data("post_rst", 32'h0000_0600, 2);
        check("post_rst_error", 32'(error), 32'd0);

        check("wlast_placement", 32'(wlast_err), 32'd0);
        check("one_outstanding", 32'(ot_viol), 32'd0);
        check("ready_gating", 32'(ready_viol), 32'd0);
        check("done_width", 32'(done_wid_viol), 32'd0);
        check("aw_constants", 32'(const_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
